slot_allocator: RTL

SLOT_ALLOCATOR -- requirements
Module: slot_allocator

---
 rtl/slot_allocator_pkg.sv | 6 +
 rtl/slot_allocator_find_first.sv | 22 ++
 rtl/slot_allocator.sv | 91 +++++++++
 3 files changed

// File: rtl/slot_allocator_pkg.sv
// Default sizing for the slot allocator; the top module takes its parameter defaults from here.
// Only sizing constants live here. Every width is passed down explicitly by parameter.
package slot_allocator_pkg;
  localparam int unsigned DEF_NUM_SLOTS = 8;
  localparam int unsigned DEF_SLOT_W    = 3;
endpackage

// File: rtl/slot_allocator_find_first.sv
// Priority encoder that scans MSB-first for the first bit equal to target_i and reports its position counted from the MSB.
// Purely combinational (0 cycles). It returns 0 when nothing matches, so callers must detect "no match" by other means.
module find_first #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DATA_DEPTH = 3
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  target_i,
  output logic [DATA_DEPTH-1:0] data_o
);

  // The highest matching bit is found last, so its position overrides any lower match.
  always_comb begin
    data_o = '0;
    for (int j = 0; j < DATA_WIDTH; j++) begin
      if (data_i[j] == target_i) begin
        data_o = DATA_DEPTH'(DATA_WIDTH - 1 - j);
      end
    end
  end

endmodule

// File: rtl/slot_allocator.sv
// Slot allocator that grants the lowest free slot index and reclaims released slots. State is updated 1 cycle after a handshake, and the error flag is registered.
// alloc_ready_o is derived only from the registered count; releases never bypass into the same-cycle grant.
module slot_allocator
  import slot_allocator_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int unsigned SLOT_W    = DEF_SLOT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_valid_i,
  output logic                 alloc_ready_o,
  output logic [SLOT_W-1:0]    alloc_id_o,
  input  logic                 release_valid_i,
  input  logic [SLOT_W-1:0]    release_id_i,
  output logic [NUM_SLOTS-1:0] occupancy_o,
  output logic [SLOT_W:0]      count_o,
  output logic                 full_o,
  output logic                 empty_o,
  output logic                 err_o
);

  logic [NUM_SLOTS-1:0] occ_q, occ_d;
  logic [SLOT_W:0]      cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [NUM_SLOTS-1:0] occ_rev;
  logic [SLOT_W-1:0]    free_idx;
  logic                 full;
  logic                 alloc_fire;
  logic                 rel_held;

  // Bit-reverse so that the MSB-first encoder reports the lowest free index directly.
  always_comb begin
    occ_rev = '0;
    for (int j = 0; j < NUM_SLOTS; j++) begin
      occ_rev[j] = occ_q[NUM_SLOTS-1-j];
    end
  end

  find_first #(
    .DATA_WIDTH (NUM_SLOTS),
    .DATA_DEPTH (SLOT_W)
  ) u_find_first (
    .data_i   (occ_rev),
    .target_i (1'b0),
    .data_o   (free_idx)
  );

  assign full       = (cnt_q == (SLOT_W+1)'(NUM_SLOTS));
  assign alloc_fire = alloc_valid_i && !full;
  assign rel_held   = occ_q[release_id_i];

  always_comb begin
    occ_d = occ_q;
    cnt_d = cnt_q;
    err_d = release_valid_i && !rel_held;
    if (release_valid_i && rel_held) begin
      occ_d[release_id_i] = 1'b0;
    end
    if (alloc_fire) begin
      occ_d[free_idx] = 1'b1;
    end
    // A grant and a legal release in the same cycle cancel out in the count.
    if (alloc_fire && !(release_valid_i && rel_held)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!alloc_fire && release_valid_i && rel_held) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign alloc_ready_o = !full;
  assign alloc_id_o    = full ? '0 : free_idx;
  assign occupancy_o   = occ_q;
  assign count_o       = cnt_q;
  assign full_o        = full;
  assign empty_o       = (cnt_q == '0);
  assign err_o         = err_q;

endmodule
